// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU, load unit and host,
// with a one-entry output stage, host lock mode and a pending-write mask for hazard stalls.
module regfile_wb_arbiter #(
    parameter int NUM_REG = 8,
    parameter int REG_AW  = 3,
    parameter int DATA_W  = 16
) (
    input  logic               clk_pi,
    input  logic               reset_pi,
    input  logic               clk_en_pi,
    input  logic               alu_valid_pi,
    input  logic [REG_AW-1:0]  alu_dest_pi,
    input  logic [DATA_W-1:0]  alu_data_pi,
    input  logic               alu_movi_lower_pi,
    input  logic               alu_movi_higher_pi,
    input  logic [7:0]         alu_immediate_pi,
    input  logic               alu_carry_pi,
    input  logic               alu_borrow_pi,
    output logic               alu_ready_po,
    input  logic               ld_valid_pi,
    input  logic [REG_AW-1:0]  ld_dest_pi,
    input  logic [DATA_W-1:0]  ld_data_pi,
    output logic               ld_ready_po,
    input  logic               host_valid_pi,
    input  logic [REG_AW-1:0]  host_dest_pi,
    input  logic [DATA_W-1:0]  host_data_pi,
    input  logic               host_lock_pi,
    output logic               host_ready_po,
    output logic               host_locked_po,
    input  logic               current_carry_pi,
    input  logic               current_borrow_pi,
    output logic               rf_clk_en_po,
    output logic               wr_destination_reg_po,
    output logic [REG_AW-1:0]  destination_reg_po,
    output logic [DATA_W-1:0]  dest_result_data_po,
    output logic               movi_lower_po,
    output logic               movi_higher_po,
    output logic [7:0]         immediate_po,
    output logic               new_carry_po,
    output logic               new_borrow_po,
    output logic [NUM_REG-1:0] pending_mask_po
);

    typedef enum logic {ARB, LOCK} state_t;

    state_t             state, state_nxt;
    logic [1:0]         rr_ptr;   // index of the last winner: 0 alu, 1 load, 2 host
    logic [2:0]         req_v, rr_gnt, gnt;

    logic               st_valid, st_alu;
    logic [REG_AW-1:0]  st_dest;
    logic [DATA_W-1:0]  st_data;
    logic               st_movi_l, st_movi_h;
    logic [7:0]         st_imm;
    logic               st_carry, st_borrow;

    assign req_v = {host_valid_pi, ld_valid_pi, alu_valid_pi};

    always_ff @(posedge clk_pi) begin
        if (reset_pi)       state <= ARB;
        else if (clk_en_pi) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:  if (host_lock_pi)  state_nxt = LOCK;
            LOCK: if (!host_lock_pi) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    // Search starts one past the last winner.
    always_comb begin
        rr_gnt = 3'b000;
        case (rr_ptr)
            2'd0: begin
                if      (req_v[1]) rr_gnt = 3'b010;
                else if (req_v[2]) rr_gnt = 3'b100;
                else if (req_v[0]) rr_gnt = 3'b001;
            end
            2'd1: begin
                if      (req_v[2]) rr_gnt = 3'b100;
                else if (req_v[0]) rr_gnt = 3'b001;
                else if (req_v[1]) rr_gnt = 3'b010;
            end
            default: begin
                if      (req_v[0]) rr_gnt = 3'b001;
                else if (req_v[1]) rr_gnt = 3'b010;
                else if (req_v[2]) rr_gnt = 3'b100;
            end
        endcase
    end

    always_comb begin
        gnt = 3'b000;
        if (clk_en_pi && !reset_pi)
            gnt = (state == LOCK) ? {req_v[2], 2'b00} : rr_gnt;
        host_locked_po = (state == LOCK);
    end

    assign alu_ready_po  = gnt[0];
    assign ld_ready_po   = gnt[1];
    assign host_ready_po = gnt[2];

    // Leaving LOCK parks the pointer on the host so the ALU is served next.
    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            rr_ptr <= 2'd2;
        end else if (clk_en_pi) begin
            if (state == LOCK && state_nxt == ARB) rr_ptr <= 2'd2;
            else if (gnt[0])                       rr_ptr <= 2'd0;
            else if (gnt[1])                       rr_ptr <= 2'd1;
            else if (gnt[2])                       rr_ptr <= 2'd2;
        end
    end

    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            st_valid  <= 1'b0;
            st_alu    <= 1'b0;
            st_dest   <= '0;
            st_data   <= '0;
            st_movi_l <= 1'b0;
            st_movi_h <= 1'b0;
            st_imm    <= '0;
            st_carry  <= 1'b0;
            st_borrow <= 1'b0;
        end else if (clk_en_pi) begin
            st_valid  <= |gnt;
            st_alu    <= gnt[0];
            st_movi_l <= gnt[0] & alu_movi_lower_pi;
            st_movi_h <= gnt[0] & alu_movi_higher_pi & ~alu_movi_lower_pi;
            st_imm    <= gnt[0] ? alu_immediate_pi : 8'h00;
            st_carry  <= alu_carry_pi;
            st_borrow <= alu_borrow_pi;
            if (gnt[0]) begin
                st_dest <= alu_dest_pi;
                st_data <= alu_data_pi;
            end else if (gnt[1]) begin
                st_dest <= ld_dest_pi;
                st_data <= ld_data_pi;
            end else if (gnt[2]) begin
                st_dest <= host_dest_pi;
                st_data <= host_data_pi;
            end
        end
    end

    // Non-ALU writes feed the live flags back so CARRY/BORROW stay unchanged.
    assign rf_clk_en_po          = st_valid & clk_en_pi;
    assign wr_destination_reg_po = st_valid;
    assign destination_reg_po    = st_valid ? st_dest : '0;
    assign dest_result_data_po   = st_valid ? st_data : '0;
    assign movi_lower_po         = st_valid & st_movi_l;
    assign movi_higher_po        = st_valid & st_movi_h;
    assign immediate_po          = st_valid ? st_imm : 8'h00;
    assign new_carry_po          = st_valid & (st_alu ? st_carry  : current_carry_pi);
    assign new_borrow_po         = st_valid & (st_alu ? st_borrow : current_borrow_pi);

    always_comb begin
        pending_mask_po = '0;
        if (st_valid) pending_mask_po[st_dest] = 1'b1;
    end

endmodule
